// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial feeder for the 1011 sequence detector.
// A word accepted over valid/ready goes through a one-word holding register.
// It is then shifted out MSB first on ser_bit, one bit per clock. While the
// line is idle it carries IDLE_BIT. When a word is waiting in the holding
// register, consecutive words leave with no gap between them.
// Optional feature: define SER_PARITY_EN to append one odd-parity bit after
// each word. That bit is sent in its own PAR state.
// dbg_state exposes the shifter state: 0 = IDLE, 1 = SHIFT, 2 = PAR.
module seq_bit_serializer #(
  parameter int   W        = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         ser_bit,
  output logic         ser_active,
  output logic         word_done,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
`ifdef SER_PARITY_EN
    ,
    S_PAR   = 2'd2
`endif
  } state_t;

  state_t          state_q;
  logic [W-1:0]    hold_q;
  logic            hold_valid_q;
  logic [W-1:0]    shift_q;
  logic [CW-1:0]   cnt_q;
  logic            ser_bit_q;
  logic            ser_active_q;
  logic            word_done_q;
`ifdef SER_PARITY_EN
  logic            par_q;
`endif
  logic            load;

  // Handshake rules:
  // - A word transfers at a rising edge where in_valid && in_ready.
  // - in_ready is high only when the holding register is empty and reset is low.
  // - in_data is captured at the transfer edge, so it may change right after.
  assign in_ready   = !hold_valid_q && !reset;
  assign ser_bit    = ser_bit_q;
  assign ser_active = ser_active_q;
  assign word_done  = word_done_q;
  assign dbg_state  = state_q;

  // Decide when the held word moves into the shifter: from IDLE, after the
  // last bit of a word, or after the parity bit.
  always_comb begin
    load = 1'b0;
    if (hold_valid_q) begin
      case (state_q)
        S_IDLE:  load = 1'b1;
`ifdef SER_PARITY_EN
        S_SHIFT: load = 1'b0;
        S_PAR:   load = 1'b1;
`else
        S_SHIFT: load = (cnt_q == '0);
`endif
        default: load = 1'b0;
      endcase
    end
  end

  // Holding register, shifter FSM and registered line outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      ser_bit_q    <= IDLE_BIT;
      ser_active_q <= 1'b0;
      word_done_q  <= 1'b0;
`ifdef SER_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      // A transfer and a load never coincide: in_ready is low while a word is held.
      if (in_valid && in_ready) begin
        hold_q       <= in_data;
        hold_valid_q <= 1'b1;
      end else if (load) begin
        hold_valid_q <= 1'b0;
      end

      if (load) begin
        state_q      <= S_SHIFT;
        shift_q      <= hold_q;
        ser_bit_q    <= hold_q[W-1];
        ser_active_q <= 1'b1;
        word_done_q  <= 1'b0;
        cnt_q        <= CW'(W - 1);
`ifdef SER_PARITY_EN
        par_q        <= ~^hold_q;
`endif
      end else begin
        case (state_q)
          S_SHIFT: begin
            if (cnt_q != '0) begin
              shift_q   <= shift_q << 1;
              ser_bit_q <= shift_q[W-2];
              cnt_q     <= cnt_q - CW'(1);
`ifdef SER_PARITY_EN
              word_done_q <= 1'b0;
`else
              word_done_q <= (cnt_q == CW'(1));
`endif
            end else begin
`ifdef SER_PARITY_EN
              state_q      <= S_PAR;
              ser_bit_q    <= par_q;
              ser_active_q <= 1'b1;
              word_done_q  <= 1'b1;
`else
              state_q      <= S_IDLE;
              ser_bit_q    <= IDLE_BIT;
              ser_active_q <= 1'b0;
              word_done_q  <= 1'b0;
`endif
            end
          end
          default: begin
            state_q      <= S_IDLE;
            ser_bit_q    <= IDLE_BIT;
            ser_active_q <= 1'b0;
            word_done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Testbench for seq_bit_serializer.
// The reference model maps each accepted word onto the edges at which its
// bits appear on the line. It uses the latency and throughput rules directly,
// independent of how the shifter is built. A per-cycle monitor compares the
// line outputs and in_ready against that map. A word scoreboard (exp_q)
// rebuilds each word from the serial line and compares it with the accepted
// word.
module tb_seq_bit_serializer;

  localparam int   W        = 8;
  localparam logic IDLE_BIT = 1'b0;
`ifdef SER_PARITY_EN
  localparam int   L        = W + 1;
  localparam bit   PAR_EN   = 1'b1;
`else
  localparam int   L        = W;
  localparam bit   PAR_EN   = 1'b0;
`endif
  localparam int   MAXC     = 4096;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         ser_bit;
  logic         ser_active;
  logic         word_done;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  seq_bit_serializer #(.W(W), .IDLE_BIT(IDLE_BIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ser_bit    (ser_bit),
    .ser_active (ser_active),
    .word_done  (word_done),
    .dbg_state  (dbg_state)
  );

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- reference model state ----------------
  int           errors = 0;
  int           checks = 0;
  bit           exp_bit  [MAXC];
  bit           exp_act  [MAXC];
  bit           exp_done [MAXC];
  bit           exp_ready;
  bit           mon_en = 1'b0;
  int           hold_s = -1;     // edge at which the held word loads, -1 if none
  int           next_free = 0;   // first edge at which the line can start a new word
  logic [W-1:0] exp_q[$];
  int           exp_end_q[$];    // edge at which each queued word's last bit appears

  // ---------------- driver ----------------
  // Drive one cycle of inputs and advance the model. The model follows these rules:
  // - A word accepted at edge N loads at edge max(N+1, end of the previous word).
  // - Its bits occupy the L edges that start at the load edge.
  // - The holding register is busy from acceptance up to the load edge.
  task automatic drive(input bit rst, input bit v, input logic [W-1:0] d, output bit acc);
    int x;
    int s;
    @(negedge clk);
    reset    = rst;
    in_valid = v;
    in_data  = d;
    #1;
    x   = edge_n;
    acc = 1'b0;
    exp_ready = !rst && (hold_s < x + 1);
    if (rst) begin
      for (int i = x + 1; i < MAXC; i++) begin
        exp_bit[i]  = IDLE_BIT;
        exp_act[i]  = 1'b0;
        exp_done[i] = 1'b0;
      end
      hold_s    = -1;
      next_free = 0;
      while (exp_end_q.size() > 0 && exp_end_q[$] > x) begin
        void'(exp_q.pop_back());
        void'(exp_end_q.pop_back());
      end
    end else if (v && exp_ready) begin
      acc = 1'b1;
      s   = (x + 2 > next_free) ? x + 2 : next_free;
      if (s + L >= MAXC) begin
        $display("FAIL model_overflow edge=%0d exceeds %0d", s + L, MAXC);
        $fatal(1);
      end
      for (int k = 0; k < W; k++) begin
        exp_bit[s + k] = d[W-1-k];
        exp_act[s + k] = 1'b1;
      end
      if (PAR_EN) begin
        exp_bit[s + W] = ~^d;
        exp_act[s + W] = 1'b1;
      end
      exp_done[s + L - 1] = 1'b1;
      next_free = s + L;
      hold_s    = s;
      exp_q.push_back(d);
      exp_end_q.push_back(s + L - 1);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  bit           mon_now;
  int           mx;
  logic [W:0]   col = '0;
  int           ncol = 0;
  logic [W-1:0] sw;
  logic [W:0]   exp_word;
  logic [W:0]   got_word;

  // Per-cycle check of the line outputs and in_ready, plus a word-level rebuild.
  initial forever begin
    @(negedge clk);
    mon_now = mon_en;
    #2;
    if (mon_now) begin
      mx = edge_n;
      checks++;
      if (ser_bit !== exp_bit[mx]) begin
        errors++;
        $display("FAIL ser_bit edge=%0d got=%b exp=%b", mx, ser_bit, exp_bit[mx]);
      end
      checks++;
      if (ser_active !== exp_act[mx]) begin
        errors++;
        $display("FAIL ser_active edge=%0d got=%b exp=%b", mx, ser_active, exp_act[mx]);
      end
      checks++;
      if (word_done !== exp_done[mx]) begin
        errors++;
        $display("FAIL word_done edge=%0d got=%b exp=%b", mx, word_done, exp_done[mx]);
      end
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("FAIL in_ready edge=%0d got=%b exp=%b", mx, in_ready, exp_ready);
      end
      if (ser_active === 1'b1) begin
        col  = {col[W-1:0], ser_bit};
        ncol = ncol + 1;
      end else begin
        col  = '0;
        ncol = 0;
      end
      if (word_done === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_sb edge=%0d got=word_done exp=no pending word", mx);
        end else begin
          sw = exp_q.pop_front();
          void'(exp_end_q.pop_front());
          exp_word = PAR_EN ? {sw, ~^sw} : {1'b0, sw};
          got_word = PAR_EN ? col : {1'b0, col[W-1:0]};
          if (got_word !== exp_word || ncol != L) begin
            errors++;
            $display("FAIL word_sb edge=%0d got=%h/%0d bits exp=%h/%0d bits",
                     mx, got_word, ncol, exp_word, L);
          end
        end
        col  = '0;
        ncol = 0;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit acc;
    drive(1'b1, 1'b0, '0, acc);
    mon_en = 1'b1;
    drive(1'b1, 1'b1, 8'hFF, acc);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    checks++;
    if (ser_bit !== IDLE_BIT || ser_active !== 1'b0 || word_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b%b exp=%b00", ser_bit, ser_active, word_done, IDLE_BIT);
    end
    drive(1'b0, 1'b0, '0, acc);
    checks++;
    if (in_ready !== 1'b1 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_idle got=ready %b state %0d exp=ready 1 state 0", in_ready, dbg_state);
    end
  endtask

  task automatic test_single();
    bit         acc;
    logic [W:0] bits = '0;
    logic [W:0] expv;
    int         nact = 0;
    int         ndone = 0;
    int         done_at = -1;
    int         first = -1;
    drive(1'b0, 1'b1, 8'hB0, acc);
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, 1'b0, '0, acc);
      if (ser_active === 1'b1) begin
        if (first < 0) first = i;
        bits = {bits[W-1:0], ser_bit};
        nact++;
      end
      if (word_done === 1'b1) begin
        ndone++;
        done_at = nact;
      end
    end
    expv = PAR_EN ? {8'hB0, 1'b0} : {1'b0, 8'hB0};
    if (!PAR_EN) bits[W] = 1'b0;
    checks++;
    if (bits !== expv) begin
      errors++; $display("FAIL single_bits got=%h exp=%h", bits, expv);
    end
    checks++;
    if (first != 1) begin
      errors++; $display("FAIL single_latency got=%0d exp=1", first);
    end
    checks++;
    if (nact != L || ndone != 1 || done_at != L) begin
      errors++;
      $display("FAIL single_framing got=act %0d done %0d at %0d exp=act %0d done 1 at %0d",
               nact, ndone, done_at, L, L);
    end
    checks++;
    if (ser_bit !== IDLE_BIT || ser_active !== 1'b0) begin
      errors++; $display("FAIL single_idle got=%b%b exp=%b0", ser_bit, ser_active, IDLE_BIT);
    end
  endtask

  task automatic test_back_to_back();
    bit           acc;
    logic [W-1:0] words[2];
    bit           exp_s[$];
    bit           got_s[$];
    int           idx = 0;
    int           runs = 0;
    int           ndone = 0;
    int           done_pos[$];
    bit           prev_act = 1'b0;
    bit           ok;
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    for (int w = 0; w < 2; w++) begin
      for (int k = W - 1; k >= 0; k--) exp_s.push_back(words[w][k]);
      if (PAR_EN) exp_s.push_back(~^words[w]);
    end
    for (int i = 0; i < 60; i++) begin
      if (idx < 2) begin
        drive(1'b0, 1'b1, words[idx], acc);
        if (acc) idx++;
      end else begin
        drive(1'b0, 1'b0, '0, acc);
      end
      if (ser_active === 1'b1) begin
        if (!prev_act) runs++;
        got_s.push_back(ser_bit);
      end
      if (word_done === 1'b1) begin
        ndone++;
        done_pos.push_back(got_s.size());
      end
      prev_act = (ser_active === 1'b1);
    end
    checks++;
    if (idx != 2) begin
      errors++; $display("FAIL b2b_accept got=%0d exp=2", idx);
    end
    checks++;
    if (runs != 1 || got_s.size() != 2 * L) begin
      errors++;
      $display("FAIL b2b_gapless got=runs %0d len %0d exp=runs 1 len %0d", runs, got_s.size(), 2 * L);
    end
    ok = (got_s.size() == exp_s.size());
    if (ok) for (int i = 0; i < exp_s.size(); i++) if (got_s[i] !== exp_s[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_bits got=%p exp=%p", got_s, exp_s);
    end
    checks++;
    if (ndone != 2 || done_pos[0] != L || done_pos[1] != 2 * L) begin
      errors++; $display("FAIL b2b_word_done got=%p exp=%0d,%0d", done_pos, L, 2 * L);
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    int nacc = 0;
    int nready = 0;
    int ndone = 0;
    int rdy_edge[$];
    for (int i = 0; i < 100 && nacc < 4; i++) begin
      drive(1'b0, 1'b1, W'($urandom), acc);
      if (in_ready === 1'b1) begin
        nready++;
        rdy_edge.push_back(edge_n);
      end
      if (word_done === 1'b1) ndone++;
      if (acc) nacc++;
    end
    for (int i = 0; i < 3 * L; i++) begin
      drive(1'b0, 1'b0, '0, acc);
      if (word_done === 1'b1) ndone++;
    end
    checks++;
    if (nready != 4) begin
      errors++; $display("FAIL bp_ready_cycles got=%0d exp=4", nready);
    end
    checks++;
    if (rdy_edge.size() < 4 || rdy_edge[2] - rdy_edge[1] != L || rdy_edge[3] - rdy_edge[2] != L) begin
      errors++; $display("FAIL bp_spacing got=%p exp=gap %0d", rdy_edge, L);
    end
    checks++;
    if (ndone != 4) begin
      errors++; $display("FAIL bp_word_count got=%0d exp=4", ndone);
    end
  endtask

  task automatic test_reset_mid_word();
    bit acc;
    int s_ff;
    int nact = 0;
    drive(1'b0, 1'b1, 8'hFF, acc);
    s_ff = edge_n + 2;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 8'h0F, acc);
      if (acc) break;
    end
    for (int i = 0; i < 10 && edge_n < s_ff + 3; i++) drive(1'b0, 1'b0, '0, acc);
    checks++;
    if (ser_active !== 1'b1 || ser_bit !== 1'b1) begin
      errors++; $display("FAIL mid_pre got=%b%b exp=11", ser_active, ser_bit);
    end
    drive(1'b1, 1'b0, '0, acc);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_ready got=%b exp=0", in_ready);
    end
    drive(1'b1, 1'b0, '0, acc);
    checks++;
    if (ser_bit !== IDLE_BIT || ser_active !== 1'b0 || word_done !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle got=%b%b%b%b exp=%b000", ser_bit, ser_active, word_done, in_ready, IDLE_BIT);
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, '0, acc);
      if (ser_active !== 1'b0) nact++;
    end
    checks++;
    if (nact != 0) begin
      errors++; $display("FAIL mid_discard got=%0d active cycles exp=0", nact);
    end
  endtask

`ifdef SER_PARITY_EN
  task automatic test_parity();
    bit           acc;
    logic [W-1:0] words[2];
    logic [W:0]   expv[2];
    logic [W:0]   bits;
    int           done_at;
    int           nact;
    words[0] = 8'h07; expv[0] = 9'b0000_0111_0;
    words[1] = 8'h03; expv[1] = 9'b0000_0011_1;
    for (int w = 0; w < 2; w++) begin
      bits = '0; nact = 0; done_at = -1;
      drive(1'b0, 1'b1, words[w], acc);
      for (int i = 0; i < 14; i++) begin
        drive(1'b0, 1'b0, '0, acc);
        if (ser_active === 1'b1) begin
          bits = {bits[W-1:0], ser_bit};
          nact++;
        end
        if (word_done === 1'b1) done_at = nact;
      end
      checks++;
      if (bits !== expv[w] || done_at != W + 1) begin
        errors++;
        $display("FAIL parity_word%0d got=%b done@%0d exp=%b done@%0d", w, bits, done_at, expv[w], W + 1);
      end
    end
  endtask
`endif

  task automatic test_random();
    bit acc;
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), W'($urandom), acc);
    end
    for (int i = 0; i < 3 * L; i++) drive(1'b0, 1'b0, '0, acc);
    checks++;
    if (ser_active !== 1'b0 || ser_bit !== IDLE_BIT) begin
      errors++; $display("FAIL random_drain got=%b%b exp=0%b", ser_active, ser_bit, IDLE_BIT);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    for (int i = 0; i < MAXC; i++) begin
      exp_bit[i]  = IDLE_BIT;
      exp_act[i]  = 1'b0;
      exp_done[i] = 1'b0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
`ifdef SER_PARITY_EN
    test_parity();
`endif
    test_random();
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream feeder for the 1011 sequence detector. Accepts parallel words over a valid/ready handshake and emits them one bit per clock, MSB first, on a single serial line (ser_bit) that drives the detector's inp_bit.
- A one-word holding register lets back-to-back words stream with no idle gap between them.
- When no data is pending, the line carries a fixed idle level.

Parameters:
- W, 8, word width in bits; legal range 2..32.
- IDLE_BIT, 0, value driven on ser_bit when the serializer is not shifting.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  W  parallel word to serialize.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  serializer can accept a word this cycle.
- ser_bit  output  1  registered serial bit; connects to the detector's inp_bit.
- ser_active  output  1  registered; high while ser_bit carries word or parity data.
- word_done  output  1  registered; one-cycle pulse while the final bit of a word is on ser_bit.

Behaviour:
- Reset (reset high at an edge): clears every register.
  - After reset: hold_valid=0, shifter idle, bit counter=0, ser_bit=IDLE_BIT, ser_active=0, word_done=0.
  - in_ready is forced 0 while reset is high. Any in_valid during reset is ignored.
- Reset mid-word: the word in flight and the held word are both discarded, with no partial completion. The next cycle shows the idle outputs.
- Handshake:
  - in_ready = !hold_valid && !reset (combinational from registers plus reset).
  - A transfer occurs at an edge where in_valid && in_ready. in_data is captured into the hold register and hold_valid is set.
  - in_data need not stay stable after the transfer.
- Shifter FSM:
  - States:
    - IDLE: shifter empty.
    - SHIFT: driving data bits W-1..0.
    - PAR: parity cycle, only when SER_PARITY_EN is defined.
  - IDLE -> SHIFT at an edge where hold_valid=1.
    - Load the shifter from the hold register and clear hold_valid.
    - Drive ser_bit = hold[W-1]; ser_active=1; counter=W-1.
  - SHIFT, counter>0: shift left; ser_bit takes the next lower bit; counter decrements.
  - SHIFT, counter==0 (bit 0 currently on the line):
    - Without parity: if hold_valid, reload as for IDLE->SHIFT (gapless); otherwise go to IDLE.
    - With parity: go to PAR.
  - PAR: if hold_valid, reload into SHIFT; otherwise go to IDLE.
  - In IDLE: ser_bit=IDLE_BIT and ser_active=0.
- Latency: for a word accepted at edge N (hold empty, shifter idle), the MSB appears on ser_bit after edge N+1. Bit k (counting from the MSB, k=0) appears after edge N+1+k.
- Throughput: with in_valid held high, one word every W cycles (W+1 with parity) with no bubbles.
  - The hold register is freed at the load edge, so in_ready rises the following cycle and the next word is accepted well before the current word ends.
- word_done: high exactly in the cycle the last bit of a word is on ser_bit (bit 0, or the parity bit when parity is enabled).
- Simultaneous events: a transfer and a hold-to-shifter load cannot coincide, because in_ready=0 whenever hold_valid=1.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - After bit 0 of each word, one extra cycle in state PAR drives an odd-parity bit: the total count of ones in word plus parity is odd.
  - ser_active stays high during PAR.
  - word_done moves from the bit-0 cycle to the PAR cycle.
- Undefined:
  - State PAR and the parity logic are absent; words are exactly W bits each, back to back.

Test Plan:
- Reset then single word: W=8, send 8'hB0 with the serializer idle.
  - ser_bit = 1,0,1,1,0,0,0,0 on consecutive cycles starting after edge N+1.
  - ser_active high for 8 cycles; word_done high on the 8th bit only.
  - Then ser_bit=0 (IDLE_BIT).
- Back-to-back: send 8'hA5 then 8'h3C with in_valid held high.
  - 16 contiguous ser_active cycles carrying bits 1010_0101_0011_1100; no idle gap.
  - word_done pulses on cycles 8 and 16.
- Backpressure: hold in_valid high continuously.
  - in_ready is low except for one cycle per word.
  - Exactly one transfer per 8 cycles; no word lost or duplicated over 4 words.
- Reset mid-word: assert reset during bit 3 of 8'hFF while 8'h0F is held.
  - Next cycle: ser_bit=0, ser_active=0, in_ready=0 while reset is high.
  - After release: idle; neither word is emitted.
- Parity (SER_PARITY_EN defined):
  - 8'h07 -> 9 bits 0000_0111 then parity 0.
  - 8'h03 -> 0000_0011 then parity 1.
  - word_done is on the parity cycle.
- Detector integration: stream 8'h2D (0010_1101) into seq_detect_1011.
  - seq_seen asserts one cycle after the 4th bit of the 1011 pattern appears on ser_bit.
